// File: rtl/ms6205_stdin.sv
// Console input path: debounces keyboard symbols, queues them in a FIFO with
// backspace line editing, echoes accepted keys, and serves bytes to the core
// over the Cin/CinAcq four-phase handshake.
// Ports:
//   Clk, Rst              clock, synchronous active-high reset
//   symbol                keyboard decoder code, 0 = no key
//   Cin / CinAcq, CinData core byte request / acknowledge with data
//   echo_valid, echo_data one-cycle strobe per accepted key, and that key
//   clear                 flush FIFO and sticky overflow
//   count, overflow       FIFO occupancy, sticky key-dropped flag
module ms6205_stdin #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned DEBOUNCE = 4,
  parameter logic [7:0]  BS_CODE  = 8'h08
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [7:0]               symbol,
  input  logic                     Cin,
  output logic                     CinAcq,
  output logic [7:0]               CinData,
  output logic                     echo_valid,
  output logic [7:0]               echo_data,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(DEBOUNCE) + 1;

  typedef enum logic {IDLE, ACK} state_t;

  state_t          state_q, state_d;
  logic [7:0]      last_sym;
  logic [SW-1:0]   stab;
  logic            latched;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      mem [DEPTH];

  logic            pop_c, accept_c, is_bs_c, push_c, bs_c, drop_c;
  logic [CW-1:0]   count_d;

  // Handshake FSM: one pop per Cin pulse; clear suppresses a new pop.
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    case (state_q)
      IDLE: if (Cin && count != '0 && !clear) begin
        state_d = ACK;
        pop_c   = 1'b1;
      end
      ACK:  if (!Cin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Key accept fires on the DEBOUNCE-th identical non-zero sample.
  always_comb begin
    accept_c = (symbol == last_sym) && (symbol != 8'h00) && !latched &&
               (stab == SW'(DEBOUNCE - 2));
    is_bs_c  = (symbol == BS_CODE);
    push_c   = accept_c && !is_bs_c && !clear &&
               ((count != CW'(DEPTH)) || pop_c);
    drop_c   = accept_c && !is_bs_c && !clear &&
               (count == CW'(DEPTH)) && !pop_c;
    // A backspace never retracts the entry being handed to the core.
    bs_c     = accept_c && is_bs_c && !clear && (count != '0) &&
               !(pop_c && count == CW'(1));
    count_d  = count + CW'(push_c) - CW'(pop_c) - CW'(bs_c);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      last_sym   <= '0;
      stab       <= '0;
      latched    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      CinAcq     <= 1'b0;
      CinData    <= '0;
      echo_valid <= 1'b0;
      echo_data  <= '0;
    end else begin
      state_q <= state_d;
      CinAcq  <= (state_d == ACK);
      if (pop_c) CinData <= mem[rd_ptr];

      if (symbol != last_sym) begin
        last_sym <= symbol;
        stab     <= '0;
        latched  <= 1'b0;
      end else if (symbol != 8'h00 && !latched) begin
        stab <= stab + SW'(1);
        if (accept_c) latched <= 1'b1;
      end

      echo_valid <= push_c || bs_c;
      if (push_c || bs_c) echo_data <= symbol;

      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        count <= count_d;
        if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
        if (push_c) wr_ptr <= wr_ptr + PW'(1);
        else if (bs_c) wr_ptr <= wr_ptr - PW'(1);
        if (drop_c) overflow <= 1'b1;
      end
    end
  end

  // Storage has no reset; only entries between the pointers are ever read.
  always_ff @(posedge Clk) begin
    if (push_c) mem[wr_ptr] <= symbol;
  end

endmodule

// File: tb/tb_ms6205_stdin.sv
module tb_ms6205_stdin;

  logic       Clk = 1'b0;
  logic       Rst, Cin, clear;
  logic [7:0] symbol;
  logic       CinAcq, echo_valid, overflow;
  logic [7:0] CinData, echo_data;
  logic [4:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] echo_q [$];
  logic [7:0] got;

  ms6205_stdin #(.DEPTH(16), .DEBOUNCE(4), .BS_CODE(8'h08)) dut (
    .Clk(Clk), .Rst(Rst), .symbol(symbol), .Cin(Cin), .CinAcq(CinAcq),
    .CinData(CinData), .echo_valid(echo_valid), .echo_data(echo_data),
    .clear(clear), .count(count), .overflow(overflow)
  );

  always #5 Clk = ~Clk;

  // Log every echo pulse; each pulse spans exactly one negedge.
  always @(negedge Clk) if (echo_valid) echo_q.push_back(echo_data);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic press(input logic [7:0] s, input int n);
    symbol = s;
    tick(n);
    symbol = 8'h00;
    tick(2);
  endtask

  // One full handshake, bounded wait for CinAcq.
  task automatic get(output logic [7:0] d);
    int w = 0;
    Cin = 1'b1;
    tick();
    while (!CinAcq && w < 20) begin
      tick();
      w++;
    end
    check("get_acq", 32'(CinAcq), 1);
    d = CinData;
    Cin = 1'b0;
    tick();
    check("get_release", 32'(CinAcq), 0);
  endtask

  initial begin
    Rst = 1'b1; Cin = 1'b0; clear = 1'b0; symbol = 8'h00;
    tick(2);
    check("rst_acq", 32'(CinAcq), 0);
    check("rst_data", 32'(CinData), 0);
    check("rst_echo", 32'(echo_valid), 0);
    check("rst_count", 32'(count), 0);
    check("rst_ovf", 32'(overflow), 0);
    Rst = 1'b0;
    tick();

    // 'A' held 10 cycles: echo on the 4th edge after the change.
    symbol = 8'h41;
    tick(3);
    check("a_no_echo_yet", 32'(echo_valid), 0);
    tick();
    check("a_echo", 32'(echo_valid), 1);
    check("a_echo_data", 32'(echo_data), 'h41);
    check("a_count", 32'(count), 1);
    tick();
    check("a_echo_pulse", 32'(echo_valid), 0);
    tick(5);
    symbol = 8'h00;
    tick(2);
    check("a_one_echo", 32'(echo_q.size()), 1);
    check("a_echo_hold", 32'(echo_data), 'h41);
    Cin = 1'b1;
    tick();
    check("a_acq", 32'(CinAcq), 1);
    check("a_cindata", 32'(CinData), 'h41);
    check("a_count0", 32'(count), 0);
    tick(3);
    check("a_acq_held", 32'(CinAcq), 1);
    Cin = 1'b0;
    tick();
    check("a_acq_drop", 32'(CinAcq), 0);
    check("a_data_hold", 32'(CinData), 'h41);

    // Glitch, then a long hold.
    echo_q.delete();
    press(8'h42, 2);
    check("glitch_echo", 32'(echo_q.size()), 0);
    check("glitch_count", 32'(count), 0);
    press(8'h42, 20);
    check("hold_echo", 32'(echo_q.size()), 1);
    check("hold_count", 32'(count), 1);
    get(got);
    check("hold_data", 32'(got), 'h42);

    // Line edit: "1","2",BS.
    echo_q.delete();
    press(8'h31, 6);
    press(8'h32, 6);
    press(8'h08, 6);
    check("bs_count", 32'(count), 1);
    check("bs_echo_n", 32'(echo_q.size()), 3);
    for (int i = 0; i < 3 && i < echo_q.size(); i++)
      check($sformatf("bs_echo%0d", i), 32'(echo_q[i]), (i == 0) ? 'h31 : (i == 1) ? 'h32 : 'h08);
    get(got);
    check("bs_data", 32'(got), 'h31);
    echo_q.delete();
    press(8'h08, 6);
    check("bs_empty_echo", 32'(echo_q.size()), 0);
    check("bs_empty_count", 32'(count), 0);

    // Fill 16 (pointers start at 3, so this wraps), overflow on 17th.
    for (int i = 0; i < 16; i++) press(8'h60 + 8'(i), 5);
    check("fill_count", 32'(count), 16);
    check("fill_ovf0", 32'(overflow), 0);
    echo_q.delete();
    press(8'h7F, 5);
    check("full_count", 32'(count), 16);
    check("full_ovf", 32'(overflow), 1);
    check("full_no_echo", 32'(echo_q.size()), 0);
    for (int i = 0; i < 16; i++) begin
      get(got);
      check($sformatf("drain%0d", i), 32'(got), 32'h60 + 32'(i));
    end
    check("drain_count", 32'(count), 0);
    check("ovf_sticky", 32'(overflow), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_ovf", 32'(overflow), 0);

    // Cin waiting on an empty FIFO.
    Cin = 1'b1;
    tick(50);
    check("wait_no_acq", 32'(CinAcq), 0);
    symbol = 8'h5A;
    tick(4);
    check("z_written", 32'(count), 1);
    check("z_not_yet", 32'(CinAcq), 0);
    tick();
    check("z_acq", 32'(CinAcq), 1);
    check("z_data", 32'(CinData), 'h5A);
    check("z_count", 32'(count), 0);
    symbol = 8'h00;
    tick(2);
    press(8'h59, 6);
    check("no_second_pop", 32'(count), 1);
    check("acq_still", 32'(CinAcq), 1);
    check("data_still", 32'(CinData), 'h5A);
    Cin = 1'b0;
    tick();
    check("z_release", 32'(CinAcq), 0);

    // Reset in the middle of a handshake with three entries queued.
    press(8'h61, 6);
    Cin = 1'b1;
    tick();
    check("pre_rst_acq", 32'(CinAcq), 1);
    check("pre_rst_data", 32'(CinData), 'h59);
    press(8'h62, 6);
    press(8'h63, 6);
    check("pre_rst_count", 32'(count), 3);
    Rst = 1'b1;
    tick();
    check("rst2_acq", 32'(CinAcq), 0);
    check("rst2_count", 32'(count), 0);
    check("rst2_ovf", 32'(overflow), 0);
    check("rst2_data", 32'(CinData), 0);
    Rst = 1'b0;
    Cin = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ms6205_stdin.md
Name: ms6205_stdin

Overview:
- Console input path for the emulator: the input-direction counterpart of the MS6205 console output capture (Cout/CioAcq into the stdio buffer).
- Debounces key symbols from the keyboard decoder and buffers them in a FIFO with line-edit backspace.
- Serves bytes to the DPC core over a Cin/CinAcq four-phase handshake, the mirror of Cout/CioAcq.
- Emits an echo strobe so typed characters also appear in the stdio display buffer.

Parameters:
- DEPTH, 16, FIFO entries (power of 2, ≥2).
- DEBOUNCE, 4, consecutive identical non-zero Clk samples required to accept a key.
- BS_CODE, 8'h08, symbol that deletes the newest unread entry.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  synchronous reset, active-high.
- symbol  in  8  keyboard decoder output; 0 = no key, held while the key is pressed.
- Cin  in  1  core requests one input byte; held until CinAcq is seen.
- CinAcq  out  1  byte valid on CinData.
- CinData  out  8  byte delivered to the core.
- echo_valid  out  1  one-cycle pulse per accepted printable key.
- echo_data  out  8  accepted symbol; valid with echo_valid.
- clear  in  1  flush FIFO and clear overflow; takes effect on the next edge.
- count  out  $clog2(DEPTH)+1  number of entries held.
- overflow  out  1  sticky: a key was dropped because the FIFO was full.

Behaviour:
- Reset (Rst=1 at a Clk edge) clears everything; all outputs become 0.
  - Outputs cleared: CinAcq, CinData, echo_valid, echo_data, count, overflow.
  - Internal state cleared: debounce counter, "key latched" flag, read/write pointers.
  - Reset mid-handshake: CinAcq drops; the core re-requests.
- Debounce:
  - Holding register last_sym and counter stab.
  - If symbol != last_sym: last_sym <= symbol, stab <= 0, latched <= 0.
  - Else if symbol != 0 and !latched: stab increments.
  - When stab reaches DEBOUNCE-1: key is accepted in that cycle and latched <= 1.
  - Exactly one accept per press. Release (symbol=0) re-arms.
  - A direct change between two non-zero codes counts as a new press.
- Accept actions (same edge):
  - Normal symbol, FIFO not full: write at wr_ptr, wr_ptr++, echo_valid <= 1, echo_data <= symbol.
  - Normal symbol, FIFO full: drop it, overflow <= 1, no echo.
  - BS_CODE, count > 0: wr_ptr--, count--; echo_valid <= 1 with echo_data = BS_CODE.
  - BS_CODE, count == 0: ignored, no echo. An entry already handed to the core is never retracted.
- echo_valid is high for exactly one cycle per accept; echo_data holds its value until the next accept.
- Core handshake (state machine, states IDLE and ACK):
  - IDLE → ACK when Cin=1 and count>0. CinData <= FIFO[rd_ptr], rd_ptr++, count--, CinAcq <= 1. Latency is 1 Clk from Cin rising with data present.
  - While Cin=1 and the FIFO is empty: remain in IDLE; serve the first accepted key on the edge after it is written (write-then-read, ≥1 cycle later).
  - ACK → IDLE when Cin=0: CinAcq <= 0. CinData holds its value.
  - Cin staying high in ACK does not pop again; one byte per Cin pulse.
- Simultaneous pop and push in the same cycle: both occur; count is unchanged.
  - Full plus simultaneous pop: the push is accepted, no overflow.
- Simultaneous pop and backspace:
  - count ≥ 2: both occur.
  - count == 1: the pop wins and the backspace is ignored.
- clear:
  - Pointers and count go to 0 and overflow goes to 0.
  - An accept in the same cycle is discarded.
  - A pending ACK completes normally.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count saturates at DEPTH and 0 by construction; never under- or over-flows.

Test Plan:
- Press 'A' (8'h41) held 10 cycles, DEBOUNCE=4 → one echo_valid pulse 4 cycles after symbol change, echo_data=8'h41, count=1. Raise Cin → CinAcq=1 next cycle, CinData=8'h41, count=0. Drop Cin → CinAcq=0.
- Glitch: symbol=8'h42 for 2 cycles then 0 → no echo, count=0. Hold 8'h42 for 20 cycles → exactly one accept.
- Type "1","2",BS → count=1, echoes 31,32,08. Cin handshake returns 8'h31. BS on empty → no echo, count=0.
- Fill 16 keys, press 17th → count=16, overflow=1, no echo. Drain 16 via handshake in order with wrap; assert clear → overflow=0.
- Cin high while empty for 50 cycles, then key 'Z' → CinAcq rises 1 cycle after the write, CinData=8'h5A. Cin held high after ACK → no second pop.
- Assert Rst during ACK with count=3 → next cycle CinAcq=0, count=0, overflow=0, CinData=0.
